alu_share_arbiter: RTL and testbench

// Shares the single integer ALU between NREQ requesters (e.g. the execute stage and the

---
 rtl/alu_share_pkg.sv | 26 ++
 rtl/alu_share_arbiter_rr_arbiter.sv | 33 +++
 rtl/alu_share_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing arbiter, the ALU and the ALU controller.
//   state_t     : arbiter sequencing states
//   ALU_*       : 4-bit Operation codes as produced by the ALU controller
//   OP_WIDTH    : width of an Operation code
package alu_share_pkg;

  localparam int unsigned OP_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_WIDTH-1:0] ALU_AND = 4'b0000;
  localparam logic [OP_WIDTH-1:0] ALU_SUB = 4'b0001;
  localparam logic [OP_WIDTH-1:0] ALU_ADD = 4'b0010;
  localparam logic [OP_WIDTH-1:0] ALU_OR  = 4'b0011;
  localparam logic [OP_WIDTH-1:0] ALU_XOR = 4'b0100;
  localparam logic [OP_WIDTH-1:0] ALU_SLL = 4'b0101;
  localparam logic [OP_WIDTH-1:0] ALU_SRL = 4'b0110;
  localparam logic [OP_WIDTH-1:0] ALU_SRA = 4'b0111;
  localparam logic [OP_WIDTH-1:0] ALU_BEQ = 4'b1000;
  localparam logic [OP_WIDTH-1:0] ALU_SLT = 4'b1001;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per requester
//   ptr       : highest-priority requester index for this decision
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted requester (zero when no request)
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int unsigned IW = $clog2(NREQ);

  // Scan from the farthest offset back to ptr so the nearest valid requester wins last.
  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + (NREQ - 1 - k)) % NREQ;
      if (req[IW'(idx)]) begin
        grant            = '0;
        grant[IW'(idx)]  = 1'b1;
        grant_idx        = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one integer ALU between NREQ requesters with round-robin arbitration.
//   clk, reset              : clock, synchronous active-high reset
//   req_valid/ready/op/a/b  : per-requester request handshake and payload
//   rsp_valid/ready/id/data : single response channel, id names the owning requester
//   alu_op/a/b              : registered operands presented to the ALU
//   alu_result              : ALU output, captured ALU_LATENCY cycles after accept
//   busy                    : an operation is in flight or awaiting response
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NREQ        = 2,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ-1:0][OP_WIDTH-1:0]       req_op,
  input  logic [NREQ-1:0][DATA_WIDTH-1:0]     req_a,
  input  logic [NREQ-1:0][DATA_WIDTH-1:0]     req_b,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [$clog2(NREQ)-1:0]             rsp_id,
  output logic [DATA_WIDTH-1:0]               rsp_data,
  output logic [OP_WIDTH-1:0]                 alu_op,
  output logic [DATA_WIDTH-1:0]               alu_a,
  output logic [DATA_WIDTH-1:0]               alu_b,
  input  logic [DATA_WIDTH-1:0]               alu_result,
  output logic                                busy
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(ALU_LATENCY + 1);

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            cnt_last;
  logic            accept;
  logic            capture;
  logic            rsp_done;

  assign cnt_last = (cnt == CW'(ALU_LATENCY - 1));

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = EXEC;
      EXEC:    if (cnt_last)   state_nxt = RESP;
      RESP:    if (rsp_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and datapath-enable decode.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant;
        accept    = |grant;
      end
      EXEC:    capture  = cnt_last;
      RESP:    rsp_done = rsp_ready;
      default: ;
    endcase
  end

  // Registered datapath: operand latch, latency counter, response holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (accept) begin
        alu_op <= req_op[grant_idx];
        alu_a  <= req_a[grant_idx];
        alu_b  <= req_b[grant_idx];
        rsp_id <= grant_idx;
        rr_ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : IW'(grant_idx + 1'b1);
        cnt    <= '0;
      end else if (state == EXEC) begin
        // Leaves EXEC at ALU_LATENCY-1, so the count never exceeds ALU_LATENCY.
        cnt <= cnt + CW'(1);
      end
      if (capture) begin
        rsp_data  <= alu_result;
        rsp_valid <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (round-robin choice, fixed latency, in-order single response).
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  localparam int unsigned DW   = 32;
  localparam int unsigned NREQ = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Latency-1 instance
  logic [NREQ-1:0]          req_valid, req_ready;
  logic [NREQ-1:0][3:0]     req_op;
  logic [NREQ-1:0][DW-1:0]  req_a, req_b;
  logic                     rsp_valid, rsp_ready, busy;
  logic [0:0]               rsp_id;
  logic [DW-1:0]            rsp_data, alu_a, alu_b, alu_result;
  logic [3:0]               alu_op;

  // Latency-3 instance
  logic [NREQ-1:0]          req_valid3, req_ready3;
  logic [NREQ-1:0][3:0]     req_op3;
  logic [NREQ-1:0][DW-1:0]  req_a3, req_b3;
  logic                     rsp_valid3, rsp_ready3, busy3;
  logic [0:0]               rsp_id3;
  logic [DW-1:0]            rsp_data3, alu_a3, alu_b3, alu_result3;
  logic [3:0]               alu_op3;

  alu_share_arbiter #(.DATA_WIDTH(DW), .NREQ(NREQ), .ALU_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .busy(busy)
  );

  alu_share_arbiter #(.DATA_WIDTH(DW), .NREQ(NREQ), .ALU_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_op(req_op3), .req_a(req_a3), .req_b(req_b3), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_data(rsp_data3), .alu_op(alu_op3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_result(alu_result3), .busy(busy3)
  );

  function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_SUB: return a - b;
      ALU_ADD: return a + b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return $signed(a) >>> b[4:0];
      ALU_BEQ: return a - b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      default: return '0;
    endcase
  endfunction

  // Latency-1 ALU is combinational; latency-3 ALU result trails its inputs by two flops.
  assign alu_result = alu_f(alu_op, alu_a, alu_b);
  logic [DW-1:0] pipe0, pipe1;
  always @(posedge clk) begin
    pipe0 <= alu_f(alu_op3, alu_a3, alu_b3);
    pipe1 <= pipe0;
  end
  assign alu_result3 = pipe1;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    req_valid3 = '0; req_op3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    #1;
    total++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got %b exp 00", req_ready); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else passed++;
    total++; if (alu_op !== 4'd0) $display("FAIL reset_alu_op got %h exp 0", alu_op); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if ({rsp_id, rsp_data, alu_a, alu_b} !== '0)
      $display("FAIL reset_regs got id=%b data=%h a=%h b=%h exp all 0", rsp_id, rsp_data, alu_a, alu_b); else passed++;
    total++; if ({rsp_valid3, busy3} !== 2'b00) $display("FAIL reset_lat3 got %b%b exp 00", rsp_valid3, busy3); else passed++;
  endtask

  task automatic test_single();
    req_valid = 2'b01; req_op[0] = ALU_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7;
    #1;
    total++; if (req_ready !== 2'b01) $display("FAIL single_accept got %b exp 01", req_ready); else passed++;
    cyc();
    req_valid = 2'b00;
    #1;
    total++; if ({alu_op, alu_a, alu_b} !== {ALU_ADD, 32'd5, 32'd7})
      $display("FAIL single_alu_in got op=%h a=%h b=%h exp op=2 a=5 b=7", alu_op, alu_a, alu_b); else passed++;
    total++; if ({rsp_valid, busy} !== 2'b01) $display("FAIL single_exec got v=%b busy=%b exp v=0 busy=1", rsp_valid, busy); else passed++;
    cyc();
    total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd12})
      $display("FAIL single_rsp got v=%b id=%b data=%0d exp v=1 id=0 data=12", rsp_valid, rsp_id, rsp_data); else passed++;
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    #1;
    total++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL single_done got v=%b busy=%b exp 0 0", rsp_valid, busy); else passed++;
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 2'b11;
    req_op[0] = ALU_ADD; req_a[0] = 32'd3; req_b[0] = 32'd4;
    req_op[1] = ALU_SUB; req_a[1] = 32'd9; req_b[1] = 32'd4;
    rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      logic [1:0]    exp_g;
      logic [DW-1:0] exp_d;
      exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (n % 2 == 0) ? 32'd7 : 32'd5;
      #1;
      total++; if (req_ready !== exp_g) $display("FAIL rr_grant%0d got %b exp %b", n, req_ready, exp_g); else passed++;
      cyc();
      cyc();
      total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'(n % 2), exp_d})
        $display("FAIL rr_rsp%0d got v=%b id=%b data=%0d exp v=1 id=%0d data=%0d", n, rsp_valid, rsp_id, rsp_data, n % 2, exp_d); else passed++;
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 2'b01; req_op[0] = ALU_AND; req_a[0] = 32'h0000_F0F0; req_b[0] = 32'h0000_FF00;
    #1;
    cyc();
    req_valid = 2'b10; req_op[1] = ALU_OR; req_a[1] = 32'd1; req_b[1] = 32'd2;
    #1;
    total++; if (req_ready !== 2'b00) $display("FAIL bp_exec_ready got %b exp 00", req_ready); else passed++;
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, 1'b0, 32'h0000_F000, 2'b00})
        $display("FAIL bp_hold%0d got v=%b id=%b data=%h rdy=%b exp v=1 id=0 data=0000f000 rdy=00", k, rsp_valid, rsp_id, rsp_data, req_ready); else passed++;
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    total++; if ({rsp_valid, req_ready} !== {1'b1, 2'b00}) $display("FAIL bp_handshake got v=%b rdy=%b exp v=1 rdy=00", rsp_valid, req_ready); else passed++;
    cyc();
    rsp_ready = 1'b0;
    #1;
    total++; if (req_ready !== 2'b10) $display("FAIL bp_next_accept got %b exp 10", req_ready); else passed++;
    cyc();
    req_valid = 2'b00;
    cyc();
    total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 32'd3})
      $display("FAIL bp_req1_rsp got v=%b id=%b data=%0d exp v=1 id=1 data=3", rsp_valid, rsp_id, rsp_data); else passed++;
    rsp_ready = 1'b1;
    cyc();
    idle_inputs();
  endtask

  task automatic test_reset_mid_exec();
    req_valid = 2'b01; req_op[0] = ALU_XOR; req_a[0] = 32'hAAAA_5555; req_b[0] = 32'hFFFF_0000;
    #1;
    cyc();
    req_valid = 2'b00;
    #1;
    total++; if (busy !== 1'b1) $display("FAIL rst_mid_busy got %b exp 1", busy); else passed++;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL rst_mid_idle%0d got v=%b busy=%b exp 0 0", k, rsp_valid, busy); else passed++;
      rsp_ready = 1'b1;
      cyc();
    end
    rsp_ready = 1'b0;
    req_valid = 2'b01; req_op[0] = ALU_SLT; req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'd1;
    #1;
    total++; if (req_ready !== 2'b01) $display("FAIL rst_mid_accept got %b exp 01", req_ready); else passed++;
    cyc();
    req_valid = 2'b00;
    cyc();
    total++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd1})
      $display("FAIL rst_mid_slt got v=%b id=%b data=%0d exp v=1 id=0 data=1", rsp_valid, rsp_id, rsp_data); else passed++;
    rsp_ready = 1'b1;
    cyc();
    idle_inputs();
  endtask

  task automatic test_latency3();
    req_valid3 = 2'b01; req_op3[0] = ALU_SRA; req_a3[0] = 32'h8000_0000; req_b3[0] = 32'd4;
    #1;
    total++; if (req_ready3 !== 2'b01) $display("FAIL lat3_accept got %b exp 01", req_ready3); else passed++;
    cyc();
    req_valid3 = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      #1;
      total++; if ({rsp_valid3, busy3} !== 2'b01) $display("FAIL lat3_wait%0d got v=%b busy=%b exp v=0 busy=1", k, rsp_valid3, busy3); else passed++;
      cyc();
    end
    total++; if ({rsp_valid3, rsp_id3, rsp_data3} !== {1'b1, 1'b0, 32'hF800_0000})
      $display("FAIL lat3_rsp got v=%b id=%b data=%h exp v=1 id=0 data=f8000000", rsp_valid3, rsp_id3, rsp_data3); else passed++;
    rsp_ready3 = 1'b1;
    cyc();
    rsp_ready3 = 1'b0;
    #1;
    total++; if (rsp_valid3 !== 1'b0) $display("FAIL lat3_done got %b exp 0", rsp_valid3); else passed++;
  endtask

  // Randomized traffic against a transaction model on the latency-1 instance.
  task automatic test_random();
    int            rr;
    bit            outst;
    int            wait_left;
    logic [3:0]    m_op;
    logic [DW-1:0] m_a, m_b;
    int            m_id;
    do_reset();
    rr = 0; outst = 0; wait_left = 0; m_op = '0; m_a = '0; m_b = '0; m_id = 0;
    for (int c = 0; c < 400; c++) begin
      int         g;
      logic [1:0] exp_ready;
      bit         exp_v;
      req_valid = 2'($urandom_range(0, 3));
      for (int i = 0; i < int'(NREQ); i++) begin
        req_op[i] = 4'($urandom_range(0, 9));
        req_a[i]  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : $urandom;
        req_b[i]  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (outst && wait_left > 0) wait_left--;
      g = -1;
      if (!outst) begin
        for (int k = int'(NREQ) - 1; k >= 0; k--)
          if (req_valid[(rr + k) % int'(NREQ)]) g = (rr + k) % int'(NREQ);
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_v = outst && (wait_left == 0);
      total++; if (req_ready !== exp_ready) $display("FAIL rnd_ready c%0d got %b exp %b", c, req_ready, exp_ready); else passed++;
      total++; if ({rsp_valid, busy} !== {exp_v, outst})
        $display("FAIL rnd_status c%0d got v=%b busy=%b exp v=%b busy=%b", c, rsp_valid, busy, exp_v, outst); else passed++;
      if (outst) begin
        total++; if ({alu_op, alu_a, alu_b} !== {m_op, m_a, m_b})
          $display("FAIL rnd_alu_in c%0d got %h %h %h exp %h %h %h", c, alu_op, alu_a, alu_b, m_op, m_a, m_b); else passed++;
      end
      if (exp_v) begin
        total++; if ({rsp_id, rsp_data} !== {1'(m_id), alu_f(m_op, m_a, m_b)})
          $display("FAIL rnd_rsp c%0d got id=%b data=%h exp id=%0d data=%h", c, rsp_id, rsp_data, m_id, alu_f(m_op, m_a, m_b)); else passed++;
        if (rsp_ready) outst = 0;
      end
      if (g >= 0) begin
        m_op = req_op[g]; m_a = req_a[g]; m_b = req_b[g]; m_id = g;
        rr = (g + 1) % int'(NREQ);
        outst = 1;
        wait_left = 2;
      end
      cyc();
    end
    idle_inputs();
    rsp_ready = 1'b1;
    repeat (4) cyc();
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_exec();
    test_latency3();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
